// File: rtl/stack_xfer_sequencer_pkg.sv
// Shared types for the 6801 stack transfer sequencer: bus-mux selects, stack op codes and
// sequence lengths.
package stack_xfer_sequencer_pkg;

  typedef enum logic [3:0] {
    MD_HI,
    MD_LO,
    ACCA,
    ACCB,
    IX_LO,
    IX_HI,
    CC,
    PC_LO,
    PC_HI,
    NONE_DOUT
  } dout_type;

  typedef enum logic [1:0] {
    PUSH_ALL = 2'd0,
    PUSH_PC  = 2'd1,
    PULL_ALL = 2'd2,
    PULL_PC  = 2'd3
  } stack_op_type;

  localparam int unsigned PUSH_ALL_LEN = 7;
  localparam int unsigned PC_LEN       = 2;
  localparam int unsigned IDX_W        = 3;

  function automatic logic is_pull_op(stack_op_type op);
    return (op == PULL_ALL) || (op == PULL_PC);
  endfunction

endpackage

// File: rtl/stack_seq_rom.sv
// Byte-order table for stack transfers: maps (op, byte index) to the register select and
// flags the final byte of the sequence.
module stack_seq_rom
  import stack_xfer_sequencer_pkg::*;
(
  input  stack_op_type     op,
  input  logic [IDX_W-1:0] idx,
  output dout_type         sel,
  output logic             last
);

  logic [IDX_W-1:0] len_m1;
  logic [IDX_W-1:0] pos;

  always_comb begin
    len_m1 = ((op == PUSH_ALL) || (op == PULL_ALL)) ? IDX_W'(PUSH_ALL_LEN - 1)
                                                    : IDX_W'(PC_LEN - 1);
    last   = (idx == len_m1);
    // Pulls unstack in the exact reverse of the push order.
    pos    = is_pull_op(op) ? (len_m1 - idx) : idx;
    sel    = NONE_DOUT;
    if (idx <= len_m1) begin
      case (pos)
        3'd0:    sel = PC_LO;
        3'd1:    sel = PC_HI;
        3'd2:    sel = IX_LO;
        3'd3:    sel = IX_HI;
        3'd4:    sel = ACCA;
        3'd5:    sel = ACCB;
        3'd6:    sel = CC;
        default: sel = NONE_DOUT;
      endcase
    end
  end

endmodule

// File: rtl/stack_xfer_sequencer.sv
// Stack transfer sequencer: walks the stack one byte per accepted memory cycle for register
// push/pull and PC push/pull, then reports the final stack pointer.
module stack_xfer_sequencer
  import stack_xfer_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  stack_op_type      op,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ready,
  input  logic [7:0]        data_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              re,
  output dout_type          dout_ctrl,
  output dout_type          ld_dst,
  output logic              ld_we,
  output logic [7:0]        ld_data,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we
);

  typedef enum logic [1:0] {StIdle, StXfer, StFinish} state_e;

  state_e            state_q;
  stack_op_type      op_q;
  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_out_q;
  logic [IDX_W-1:0]  idx_q;
  logic [ADDR_W-1:0] sp_step;
  logic              pull;
  dout_type          rom_sel;
  logic              rom_last;

  stack_seq_rom u_rom (
    .op   (op_q),
    .idx  (idx_q),
    .sel  (rom_sel),
    .last (rom_last)
  );

  assign pull    = is_pull_op(op_q);
  assign sp_step = pull ? (sp_q + ADDR_W'(1)) : (sp_q - ADDR_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= PUSH_ALL;
      sp_q     <= '0;
      sp_out_q <= '0;
      idx_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= op;
            sp_q    <= sp_in;
            idx_q   <= '0;
            state_q <= StXfer;
          end
        end
        StXfer: begin
          if (mem_ready) begin
            sp_q  <= sp_step;
            idx_q <= idx_q + IDX_W'(1);
            if (rom_last) begin
              sp_out_q <= sp_step;
              state_q  <= StFinish;
            end
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    addr      = '0;
    we        = 1'b0;
    re        = 1'b0;
    dout_ctrl = NONE_DOUT;
    ld_dst    = NONE_DOUT;
    if (state_q == StXfer) begin
      if (pull) begin
        // Pull reads the byte just above SP, which is exactly the post-increment value.
        addr   = sp_step;
        re     = 1'b1;
        ld_dst = rom_sel;
      end else begin
        addr      = sp_q;
        we        = 1'b1;
        dout_ctrl = rom_sel;
      end
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StFinish);
  assign sp_we   = done;
  assign sp_out  = sp_out_q;
  assign ld_we   = re & mem_ready;
  assign ld_data = data_in;

endmodule

// File: tb/tb_stack_xfer_sequencer.sv
// Directed bench for stack_xfer_sequencer: table of full sequences plus stall, restart and
// mid-sequence reset cases.
module tb_stack_xfer_sequencer;
  import stack_xfer_sequencer_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         start;
  stack_op_type op;
  logic [15:0]  sp_in;
  logic         mem_ready;
  logic [7:0]   data_in;
  logic         busy;
  logic         done;
  logic [15:0]  addr;
  logic         we;
  logic         re;
  dout_type     dout_ctrl;
  dout_type     ld_dst;
  logic         ld_we;
  logic [7:0]   ld_data;
  logic [15:0]  sp_out;
  logic         sp_we;

  int n_chk  = 0;
  int n_fail = 0;

  stack_xfer_sequencer #(.ADDR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .sp_in     (sp_in),
    .mem_ready (mem_ready),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .addr      (addr),
    .we        (we),
    .re        (re),
    .dout_ctrl (dout_ctrl),
    .ld_dst    (ld_dst),
    .ld_we     (ld_we),
    .ld_data   (ld_data),
    .sp_out    (sp_out),
    .sp_we     (sp_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    stack_op_type         op;
    logic [15:0]          sp_in;
    logic [7:0]           data_base;
    logic [2:0]           len;
    logic [0:6][15:0]     addr;
    logic [0:6][3:0]      sel;
    logic [15:0]          sp_out;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    logic push;
    v = tbl[k];
    push = (v.op == PUSH_ALL) || (v.op == PUSH_PC);
    start = 1'b1;
    op = v.op;
    sp_in = v.sp_in;
    mem_ready = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_idle_busy", k), busy, 0);
    next_cycle();
    start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      data_in = v.data_base + 8'(i);
      @(negedge clk);
      check($sformatf("v%0d_b%0d_addr", k, i), addr, v.addr[i]);
      check($sformatf("v%0d_b%0d_we", k, i), we, push);
      check($sformatf("v%0d_b%0d_re", k, i), re, !push);
      check($sformatf("v%0d_b%0d_done", k, i), done, 0);
      if (push) begin
        check($sformatf("v%0d_b%0d_dout", k, i), dout_ctrl, v.sel[i]);
        check($sformatf("v%0d_b%0d_lddst", k, i), ld_dst, NONE_DOUT);
        check($sformatf("v%0d_b%0d_ldwe", k, i), ld_we, 0);
      end else begin
        check($sformatf("v%0d_b%0d_lddst", k, i), ld_dst, v.sel[i]);
        check($sformatf("v%0d_b%0d_dout", k, i), dout_ctrl, NONE_DOUT);
        check($sformatf("v%0d_b%0d_ldwe", k, i), ld_we, 1);
        check($sformatf("v%0d_b%0d_lddata", k, i), ld_data, v.data_base + 8'(i));
      end
      next_cycle();
    end
    @(negedge clk);
    check($sformatf("v%0d_done", k), done, 1);
    check($sformatf("v%0d_spwe", k), sp_we, 1);
    check($sformatf("v%0d_spout", k), sp_out, v.sp_out);
    check($sformatf("v%0d_fin_strobes", k), {we, re, ld_we}, 3'b000);
    check($sformatf("v%0d_fin_sel", k), {dout_ctrl, ld_dst}, {NONE_DOUT, NONE_DOUT});
    next_cycle();
  endtask

  initial begin
    int reads;
    int writes;
    int dones;

    tbl[0] = '{op: PUSH_ALL, sp_in: 16'h00FF, data_base: 8'h00, len: 3'd7,
               addr: {16'h00FF, 16'h00FE, 16'h00FD, 16'h00FC, 16'h00FB, 16'h00FA, 16'h00F9},
               sel: {PC_LO, PC_HI, IX_LO, IX_HI, ACCA, ACCB, CC}, sp_out: 16'h00F8};
    tbl[1] = '{op: PULL_ALL, sp_in: 16'h00F8, data_base: 8'h10, len: 3'd7,
               addr: {16'h00F9, 16'h00FA, 16'h00FB, 16'h00FC, 16'h00FD, 16'h00FE, 16'h00FF},
               sel: {CC, ACCB, ACCA, IX_HI, IX_LO, PC_HI, PC_LO}, sp_out: 16'h00FF};
    tbl[2] = '{op: PUSH_PC, sp_in: 16'h0001, data_base: 8'h00, len: 3'd2,
               addr: {16'h0001, 16'h0000, {5{16'h0000}}},
               sel: {PC_LO, PC_HI, {5{NONE_DOUT}}}, sp_out: 16'hFFFF};
    tbl[3] = '{op: PULL_PC, sp_in: 16'hFFFF, data_base: 8'hA5, len: 3'd2,
               addr: {16'h0000, 16'h0001, {5{16'h0000}}},
               sel: {PC_HI, PC_LO, {5{NONE_DOUT}}}, sp_out: 16'h0001};
    tbl[4] = '{op: PUSH_ALL, sp_in: 16'h0010, data_base: 8'h00, len: 3'd7,
               addr: {16'h0010, 16'h000F, 16'h000E, 16'h000D, 16'h000C, 16'h000B, 16'h000A},
               sel: {PC_LO, PC_HI, IX_LO, IX_HI, ACCA, ACCB, CC}, sp_out: 16'h0009};

    rst_n = 1'b0;
    start = 1'b0;
    op = PUSH_ALL;
    sp_in = 16'h0000;
    mem_ready = 1'b0;
    data_in = 8'h00;
    #2;
    check("rst_busy_done", {busy, done, sp_we}, 3'b000);
    check("rst_strobes", {we, re, ld_we}, 3'b000);
    check("rst_addr", addr, 16'h0000);
    check("rst_spout", sp_out, 16'h0000);
    check("rst_sel", {dout_ctrl, ld_dst}, {NONE_DOUT, NONE_DOUT});
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // Back-to-back: each run starts in the cycle right after the previous done.
    for (int k = 0; k < 4; k++) run_vec(k);

    // PUSH_PC with byte 0 stalled for 3 cycles.
    start = 1'b1;
    op = PUSH_PC;
    sp_in = 16'h0100;
    mem_ready = 1'b0;
    next_cycle();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("stall_c%0d_addr", c), addr, 16'h0100);
      check($sformatf("stall_c%0d_we_dout", c), {we, dout_ctrl}, {1'b1, PC_LO});
      check($sformatf("stall_c%0d_done", c), done, 0);
      next_cycle();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("stall_c4_addr", addr, 16'h0100);
    next_cycle();
    @(negedge clk);
    check("stall_c5_addr_dout", {addr, dout_ctrl}, {16'h00FF, PC_HI});
    next_cycle();
    @(negedge clk);
    check("stall_c6_done", {done, sp_we}, 2'b11);
    check("stall_c6_spout", sp_out, 16'h00FE);
    next_cycle();

    // Extra start pulses during a PULL_ALL must be ignored.
    start = 1'b1;
    op = PULL_ALL;
    sp_in = 16'h2000;
    next_cycle();
    reads = 0;
    writes = 0;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      start = (c == 2) || (c == 5);
      op = PUSH_ALL;
      sp_in = 16'h5555;
      @(negedge clk);
      reads += int'(re & mem_ready);
      writes += int'(we);
      dones += int'(done);
      next_cycle();
    end
    start = 1'b0;
    check("restart_reads", reads, 7);
    check("restart_writes", writes, 0);
    check("restart_dones", dones, 1);
    check("restart_spout", sp_out, 16'h2007);

    // Reset asserted in cycle 3 of a PUSH_ALL.
    start = 1'b1;
    op = PUSH_ALL;
    sp_in = 16'h0300;
    next_cycle();
    start = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy_done", {busy, done, sp_we}, 3'b000);
    check("mid_rst_strobes", {we, re, ld_we}, 3'b000);
    check("mid_rst_addr", addr, 16'h0000);
    check("mid_rst_spout", sp_out, 16'h0000);
    check("mid_rst_sel", {dout_ctrl, ld_dst}, {NONE_DOUT, NONE_DOUT});
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    run_vec(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
